pm_rate_meter: RTL
==================

// Module: pm_rate_meter
// PURPOSE
//  Receive-side rate monitor for paced traffic: counts frame-arrival pulses over a fixed window of
//  clk cycles and checks the count against the expected rate for SIZE-byte frames at BANDWIDTH bit/s.
//  Sits at the sink end of a paced link, fed one pulse per accepted frame (e.g. tvalid&tready&tlast).
//  Results go to the status/CSR block as held registers plus a one-cycle result_valid strobe.
// PARAMETERS
//  SIZE           64          frame length in bytes
//  FREQUENCY      350000000   clk frequency, Hz
//  BANDWIDTH      1000000000  nominal link rate, bit/s
//  WINDOW_CYCLES  350000      measurement window length, clk cycles (>=2)
//  TOLERANCE_PPT  10          accepted deviation from expected count, parts per thousand
// PORTS
//  clk           in   1      clock
//  rst           in   1      reset, asynchronous, active-high
//  enable        in   1      level; high = measure continuously, low = abort and idle
//  frame_pulse   in   1      one-cycle pulse per received frame
//  busy          out  1      high in SYNC or MEASURE
//  result_valid  out  1      one-cycle strobe: results below updated this cycle
//  frame_count   out  CNT_W  frames counted in last completed window (saturating)
//  rate_low      out  1      frame_count < EXP_LO
//  rate_high     out  1      frame_count > EXP_HI
//  rate_ok       out  1      EXP_LO <= frame_count <= EXP_HI
//  window_count  out  16     completed windows since enable rose; wraps 65535->0
//  min_gap       out  GAP_W  [PM_METER_GAP_STATS_EN] shortest inter-pulse gap in window, cycles
//  max_gap       out  GAP_W  [PM_METER_GAP_STATS_EN] longest inter-pulse gap in window, cycles
// BEHAVIOUR
//  Constants (64-bit elaboration arithmetic; 32-bit integer overflow not allowed):
//   EXP = (WINDOW_CYCLES*BANDWIDTH)/(SIZE*8*FREQUENCY), truncated; DEV = (EXP*TOLERANCE_PPT)/1000;
//   EXP_LO = EXP-DEV; EXP_HI = EXP+DEV; CNT_W = $clog2(2*EXP_HI+2); GAP_W = $clog2(WINDOW_CYCLES+1).
//  Reset: state IDLE; all outputs 0 (min_gap all-ones, max_gap 0); internal counters 0.
//  FSM: IDLE -(enable)-> SYNC -(frame_pulse)-> MEASURE; any state -(!enable)-> IDLE in 1 cycle.
//   SYNC aligns the window to the first frame; that pulse counts as frame 1, cycle index 0.
//   MEASURE: cycle index increments each clk; on index == WINDOW_CYCLES-1 (terminal cycle):
//    latch count (including a pulse in the terminal cycle) to frame_count, set rate flags,
//    assert result_valid for exactly that next cycle, increment window_count, restart index at 0
//    with count 0; no dead cycle between windows. A pulse in the first cycle of the new window
//    counts in the new window. Latency: results visible 1 cycle after the terminal cycle.
//  Count saturates at 2^CNT_W-1 (then rate_high=1). Flags mutually exclusive, one-hot after 1st result.
//  Leaving MEASURE via !enable discards the partial window: no result_valid, outputs hold last
//   result; window_count clears on the next IDLE->SYNC transition.
//  enable re-asserted while IDLE re-enters SYNC; rst mid-window returns everything to reset values.
// CONFIGURATION
//  `PM_METER_GAP_STATS_EN defined: track cycles between consecutive pulses within a window; gap =
//   index difference; first pulse of a window has no gap; latched with frame_count; window with
//   <2 pulses reports min_gap=all-ones, max_gap=0. Gap counter saturates at 2^GAP_W-1.
//  Undefined: min_gap/max_gap ports absent, no gap logic synthesised.
// STRUCTURE
//  Package pm_pkg: state enum (IDLE,SYNC,MEASURE), function pm_expected_frames(size,freq,bw,window)
//   shared with pm_counter-side rate math, tolerance helpers.
//  Sub-module pm_gap_tracker (only under the macro): pulse, window_restart -> running min/max gap.
// TESTING (SIZE=1, FREQUENCY=100, BANDWIDTH=80, WINDOW_CYCLES=1000, TOLERANCE_PPT=50:
//          EXP=100, EXP_LO=95, EXP_HI=105)
//  1 pulse every 10 cycles, enable=1 -> result_valid every 1000 cycles, frame_count=100, rate_ok=1,
//    window_count 1,2,3; with macro min_gap=max_gap=10.
//  pulse every 11 cycles -> frame_count=91, rate_low=1; every 9 cycles -> frame_count=112, rate_high=1.
//  enable=1, no pulses -> stays SYNC, busy=1, no result_valid; first pulse starts window.
//  pulse on terminal cycle and on next cycle -> first counted in ending window, second in new.
//  enable low at cycle 500 -> IDLE next cycle, no result_valid, outputs hold; rst at cycle 500 -> all 0.
//  pulse every cycle -> count saturates at 2^CNT_W-1 (CNT_W=8: 255), rate_high=1; with macro min_gap=1.

Source files
------------

// File: rtl/pm_pkg.sv
// Shared types and elaboration-time rate math for the paced-link rate meter.
package pm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        MEASURE = 2'd2
    } pm_state_t;

    // All rate math is 64-bit so realistic link rates cannot overflow at elaboration.
    function automatic longint unsigned pm_expected_frames(input longint unsigned size,
                                                           input longint unsigned freq,
                                                           input longint unsigned bw,
                                                           input longint unsigned window);
        return (window * bw) / (size * 64'd8 * freq);
    endfunction

    function automatic longint unsigned pm_deviation(input longint unsigned expected,
                                                     input longint unsigned ppt);
        return (expected * ppt) / 64'd1000;
    endfunction

    function automatic longint unsigned pm_exp_lo(input longint unsigned expected,
                                                  input longint unsigned ppt);
        return expected - pm_deviation(expected, ppt);
    endfunction

    function automatic longint unsigned pm_exp_hi(input longint unsigned expected,
                                                  input longint unsigned ppt);
        return expected + pm_deviation(expected, ppt);
    endfunction

endpackage

// File: rtl/pm_gap_tracker.sv
// Running min/max of inter-pulse gaps within a measurement window (PM_METER_GAP_STATS_EN builds only).
module pm_gap_tracker #(
    parameter int GAP_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active,
    input  logic             restart,
    input  logic             pulse,
    input  logic             terminal,
    output logic [GAP_W-1:0] min_gap,
    output logic [GAP_W-1:0] max_gap
);

    localparam logic [GAP_W-1:0] GAP_MAX = '1;

    logic [GAP_W-1:0] since;
    logic [GAP_W-1:0] run_min;
    logic [GAP_W-1:0] run_max;
    logic [GAP_W-1:0] new_min;
    logic [GAP_W-1:0] new_max;
    logic [GAP_W-1:0] eff_min;
    logic [GAP_W-1:0] eff_max;
    logic             seen;
    logic             eff_seen;
    logic             have_gap;

    // restart marks cycle index 0: the previous window's history is ignored from here on.
    always_comb begin
        eff_seen = seen & ~restart;
        eff_min  = restart ? GAP_MAX : run_min;
        eff_max  = restart ? '0 : run_max;
        have_gap = pulse & eff_seen;
        new_min  = (have_gap && since < eff_min) ? since : eff_min;
        new_max  = (have_gap && since > eff_max) ? since : eff_max;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            since   <= '0;
            seen    <= 1'b0;
            run_min <= GAP_MAX;
            run_max <= '0;
            min_gap <= GAP_MAX;
            max_gap <= '0;
        end else if (active) begin
            run_min <= new_min;
            run_max <= new_max;
            if (pulse) begin
                since <= GAP_W'(1);
                seen  <= 1'b1;
            end else begin
                seen <= eff_seen;
                if (since != GAP_MAX)
                    since <= since + GAP_W'(1);
            end
            if (terminal) begin
                min_gap <= new_min;
                max_gap <= new_max;
            end
        end
    end

endmodule

// File: rtl/pm_rate_meter.sv
// Frame-rate monitor: counts frame pulses over a fixed clk window and flags low/ok/high.
// Define PM_METER_GAP_STATS_EN to add min_gap/max_gap inter-pulse statistics.
//
// state   | meaning
// IDLE    | disabled, outputs hold last result
// SYNC    | enabled, waiting for the first frame to align the window
// MEASURE | counting frames; results latched on each terminal cycle
module pm_rate_meter
    import pm_pkg::*;
#(
    parameter int unsigned SIZE          = 64,
    parameter int unsigned FREQUENCY     = 350000000,
    parameter int unsigned BANDWIDTH     = 1000000000,
    parameter int unsigned WINDOW_CYCLES = 350000,
    parameter int unsigned TOLERANCE_PPT = 10,
    localparam longint unsigned EXP    = pm_expected_frames(64'(SIZE), 64'(FREQUENCY),
                                                            64'(BANDWIDTH), 64'(WINDOW_CYCLES)),
    localparam longint unsigned EXP_LO = pm_exp_lo(EXP, 64'(TOLERANCE_PPT)),
    localparam longint unsigned EXP_HI = pm_exp_hi(EXP, 64'(TOLERANCE_PPT)),
    localparam int CNT_W = $clog2(2 * EXP_HI + 2)
`ifdef PM_METER_GAP_STATS_EN
    ,
    localparam int GAP_W = $clog2(64'(WINDOW_CYCLES) + 1)
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             frame_pulse,
    output logic             busy,
    output logic             result_valid,
    output logic [CNT_W-1:0] frame_count,
    output logic             rate_low,
    output logic             rate_high,
    output logic             rate_ok,
    output logic [15:0]      window_count
`ifdef PM_METER_GAP_STATS_EN
    ,
    output logic [GAP_W-1:0] min_gap,
    output logic [GAP_W-1:0] max_gap
`endif
);

    localparam int IDX_W = $clog2(WINDOW_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LO   = CNT_W'(EXP_LO);
    localparam logic [CNT_W-1:0] CNT_HI   = CNT_W'(EXP_HI);

    pm_state_t        state;
    pm_state_t        state_next;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             arm;
    logic             start;
    logic             terminal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        arm        = 1'b0;
        start      = 1'b0;
        terminal   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = SYNC;
                    arm        = 1'b1;
                end
            end
            SYNC: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (frame_pulse) begin
                    state_next = MEASURE;
                    start      = 1'b1;
                end
            end
            MEASURE: begin
                if (!enable)
                    state_next = IDLE;
                else if (idx == IDX_LAST)
                    terminal = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign cnt_next = (frame_pulse && cnt != CNT_MAX) ? cnt + CNT_W'(1) : cnt;

    // The aligning pulse in SYNC is index 0 / frame 1, so MEASURE starts at index 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx          <= '0;
            cnt          <= '0;
            frame_count  <= '0;
            rate_low     <= 1'b0;
            rate_high    <= 1'b0;
            rate_ok      <= 1'b0;
            result_valid <= 1'b0;
            window_count <= '0;
        end else begin
            result_valid <= 1'b0;
            if (arm)
                window_count <= '0;
            if (start) begin
                idx <= IDX_W'(1);
                cnt <= CNT_W'(1);
            end else if (state == MEASURE && enable) begin
                if (terminal) begin
                    idx          <= '0;
                    cnt          <= '0;
                    frame_count  <= cnt_next;
                    rate_low     <= (cnt_next < CNT_LO);
                    rate_high    <= (cnt_next > CNT_HI);
                    rate_ok      <= (cnt_next >= CNT_LO) && (cnt_next <= CNT_HI);
                    result_valid <= 1'b1;
                    window_count <= window_count + 16'd1;
                end else begin
                    idx <= idx + IDX_W'(1);
                    cnt <= cnt_next;
                end
            end
        end
    end

`ifdef PM_METER_GAP_STATS_EN
    logic gap_active;
    logic gap_restart;

    assign gap_active  = start | (state == MEASURE && enable);
    assign gap_restart = start | (state == MEASURE && idx == '0);

    pm_gap_tracker #(
        .GAP_W (GAP_W)
    ) u_gap_tracker (
        .clk      (clk),
        .rst      (rst),
        .active   (gap_active),
        .restart  (gap_restart),
        .pulse    (frame_pulse),
        .terminal (terminal),
        .min_gap  (min_gap),
        .max_gap  (max_gap)
    );
`endif

endmodule
